// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS core.
// Covers exception codes, PC select encodings, CP0 indices and FSM states.
package cpu_pkg;

    // Exception codes written to CP0 Cause.ExcCode
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_TR  = 5'd13;

    // PC mux select
    localparam logic [1:0] PC_NORM = 2'b00;
    localparam logic [1:0] PC_VEC  = 2'b01;
    localparam logic [1:0] PC_EPC  = 2'b10;

    // CP0 register indices
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Exception sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_RET  = 2'd2,
        ST_HOLD = 2'd3
    } exc_state_t;

endpackage

// File: rtl/irq_latch.sv
// External interrupt edge detector and pending register.
// A rising edge sets a pend bit; a clear pulse drops it, and a set wins.
module irq_latch
    import cpu_pkg::*;
#(
    parameter int NIRQ = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NIRQ-1:0] i_irq,
    input  logic [NIRQ-1:0] i_clr,
    output logic [NIRQ-1:0] o_pend
);

    logic [NIRQ-1:0] r_prev;
    logic [NIRQ-1:0] r_pend;
    logic [NIRQ-1:0] w_rise;

    assign w_rise = i_irq & ~r_prev;
    assign o_pend = r_pend;

    // Track previous line levels and latch rising edges until taken
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= i_irq;
            r_pend <= (r_pend & ~i_clr) | w_rise;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between the main control unit and CP0.
// Prioritises traps and interrupts, pulses CP0 save/return and steers the PC.
module exc_ctrl
    import cpu_pkg::*;
#(
    parameter int NIRQ    = 5,
    parameter int VEC_CYC = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_instr_done,
    input  logic            i_syscall,
    input  logic            i_brk,
    input  logic            i_teq_trap,
    input  logic            i_eret_req,
    input  logic [NIRQ-1:0] i_ext_irq,
    input  logic [31:0]     i_status,
    output logic            o_exception,
    output logic            o_eret,
    output logic [4:0]      o_cause,
    output logic [1:0]      o_pc_sel,
    output logic            o_hold,
    output logic [NIRQ-1:0] o_irq_pend
);

    localparam int CW = (VEC_CYC > 1) ? $clog2(VEC_CYC) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(VEC_CYC - 1);

    exc_state_t      r_state;
    exc_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [4:0]      w_code;
    logic [NIRQ-1:0] w_pend;
    logic [NIRQ-1:0] w_masked;
    logic [NIRQ-1:0] w_irq_oh;
    logic [NIRQ-1:0] w_clr;
    logic            w_irq_ok;

    logic            r_exception;
    logic            r_eret;
    logic [4:0]      r_cause;
    logic [1:0]      r_pc_sel;
    logic            r_hold;

    // Status bits outside IE and IM carry nothing for this block
    logic w_unused_status;
    assign w_unused_status = ^{i_status[31:8+NIRQ], i_status[7:1]};

    irq_latch #(
        .NIRQ(NIRQ)
    ) u_irq_latch (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_irq  (i_ext_irq),
        .i_clr  (w_clr),
        .o_pend (w_pend)
    );

    // Lowest pending, unmasked line wins; IE gates everything
    assign w_masked = w_pend & i_status[8 +: NIRQ];
    assign w_irq_oh = w_masked & (~w_masked + 1'b1);
    assign w_irq_ok = i_status[0] & (|w_masked);

    // Next-state, exception code and pend-clear selection
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code      = EXC_INT;
        w_clr       = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_instr_done) begin
                    if (i_eret_req) begin
                        w_state_nxt = ST_RET;
                    end else if (i_syscall) begin
                        w_state_nxt = ST_SAVE;
                        w_code      = EXC_SYS;
                    end else if (i_brk) begin
                        w_state_nxt = ST_SAVE;
                        w_code      = EXC_BP;
                    end else if (i_teq_trap) begin
                        w_state_nxt = ST_SAVE;
                        w_code      = EXC_TR;
                    end else if (w_irq_ok) begin
                        w_state_nxt = ST_SAVE;
                        w_code      = EXC_INT;
                        w_clr       = w_irq_oh;
                    end
                end
            end
            ST_SAVE, ST_RET: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = HOLD_LAST;
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
        endcase
    end

    // State and registered outputs decoded from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_exception <= 1'b0;
            r_eret      <= 1'b0;
            r_cause     <= 5'd0;
            r_pc_sel    <= PC_NORM;
            r_hold      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_exception <= (w_state_nxt == ST_SAVE);
            r_eret      <= (w_state_nxt == ST_RET);
            r_cause     <= (w_state_nxt == ST_SAVE) ? w_code : 5'd0;
            r_pc_sel    <= (w_state_nxt == ST_SAVE) ? PC_VEC :
                           (w_state_nxt == ST_RET)  ? PC_EPC : PC_NORM;
            r_hold      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_exception = r_exception;
    assign o_eret      = r_eret;
    assign o_cause     = r_cause;
    assign o_pc_sel    = r_pc_sel;
    assign o_hold      = r_hold;
    assign o_irq_pend  = w_pend;

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer for the multicycle MIPS core. It sits between the main control unit and CP0. At instruction boundaries it collects synchronous trap requests (syscall, break, teq) and latched external interrupts, prioritises them and gates interrupts with the CP0 status register. It then sequences CP0 through save and return with one-cycle control pulses and steers the PC to the vector or to EPC.

## Interface
- `NIRQ`, default 5: number of external interrupt lines; mapped to status[8+NIRQ-1:8].
- `VEC_CYC`, default 1: hold cycles after a save or return, before the core resumes.

Ports:
- `clk`, in, 1: core clock; all state on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `instr_done`, in, 1: pulse on the last cycle of an instruction; the only accept point.
- `syscall`, in, 1: current instruction is SYSCALL (valid with `instr_done`).
- `brk`, in, 1: current instruction is BREAK.
- `teq_trap`, in, 1: TEQ with equal operands.
- `eret_req`, in, 1: current instruction is ERET.
- `ext_irq`, in, NIRQ: level interrupt lines.
- `status`, in, 32: CP0 status; bit0 is global IE, bits [8+NIRQ-1:8] are IM.
- `exception`, out, 1: one-cycle pulse to CP0 save.
- `eret`, out, 1: one-cycle pulse to CP0 return.
- `cause`, out, 5: ExcCode to CP0, valid while `exception`=1; 0 otherwise.
- `pc_sel`, out, 2: 00 = normal, 01 = vector (CP0 exc_addr), 10 = EPC.
- `hold`, out, 1: stall the control unit; high in every non-IDLE state.
- `irq_pend`, out, NIRQ: latched interrupt pending bits (debug and visibility).

## Operation
- **Interrupt latching:** `irq_pend` is set on a rising edge of `ext_irq[i]` (previous-cycle register). It is cleared only when that interrupt is taken. Set and clear in the same cycle: set wins.
- **Accept rule:** evaluated only in IDLE with `instr_done`=1. Priority, highest first:
  - `eret_req`
  - `syscall` (ExcCode 8)
  - `brk` (9)
  - `teq_trap` (13)
  - interrupt (ExcCode 0), only if `status[0]`=1 and (`irq_pend` & IM) ≠ 0; the lowest index wins, and only that bit clears.
  - Lower-priority requests in the same cycle are dropped, except interrupt pend bits, which stay latched.
- **States:** IDLE, SAVE, RET, HOLD.
  - IDLE → SAVE on an accepted exception or interrupt.
  - IDLE → RET on `eret_req`.
  - SAVE: `exception`=1, `cause` = code, `pc_sel`=01, one cycle → HOLD.
  - RET: `eret`=1, `pc_sel`=10, one cycle → HOLD.
  - HOLD: counts `VEC_CYC` cycles with `pc_sel` = 00 → IDLE.
- **Interaction with CP0:** CP0 writes on negedge, so the SAVE/RET pulses are sampled mid-cycle. The mask is re-read from `status` after the save; because CP0 shifts status, IE is cleared and nested interrupts are blocked naturally.
- **Ignored inputs:** `instr_done` and all requests are ignored outside IDLE. The control unit guarantees `instr_done` is not pulsed while `hold`=1.
- **Invariant:** `exception` and `eret` are never high together.

## Timing
- **Reset values:** on a `rst` cycle, state = IDLE. All outputs become 0 on the following edge: `exception`, `eret`, `cause`, `pc_sel`, `hold`, `irq_pend`. The edge-detect register also clears.
- **Reset mid-sequence:** returns to IDLE immediately with no pulse emitted.
- **Latency:** `instr_done` at cycle N gives the `exception`/`eret` pulse in cycle N+1. `hold` is high for N+1 .. N+1+`VEC_CYC`, and the core resumes at N+2+`VEC_CYC`.
- **Interrupt pending:** a rising `ext_irq` at cycle N is visible in `irq_pend` at N+1 and is eligible at the first `instr_done` from N+1 on.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared package `cpu_pkg`:**
  - ExcCode constants: EXC_INT=0, EXC_SYS=8, EXC_BP=9, EXC_TR=13.
  - PC select encodings: PC_NORM, PC_VEC, PC_EPC.
  - CP0 register indices: STATUS=12, CAUSE=13, EPC=14.
  - FSM state enum.
- **Sub-module `irq_latch`:** edge detect plus the pend register with a per-bit clear, NIRQ wide. The FSM and priority logic stay in `exc_ctrl`.

## Test plan
- **Syscall:** `syscall`=1 with `instr_done` at N → at N+1 `exception`=1, `cause`=8, `pc_sel`=01; `hold`=1 for N+1..N+2; IDLE at N+3.
- **Simultaneous requests:** `brk`=1, `teq_trap`=1 and `ext_irq[2]` pending with IE=1, IM=all → `cause`=9; `irq_pend`[2] stays 1.
- **Masked interrupt:** `ext_irq[1]` rises, status = 0x0000_0201 (IM bit1 = 1... set IM[1]) → next `instr_done` gives `cause`=0, `irq_pend`[1] clears. With status[0]=0 → no exception; the bit stays pending.
- **ERET:** `eret_req` with `instr_done` → `eret`=1, `pc_sel`=10 for one cycle, `exception`=0.
- **Ignored while busy:** `instr_done`/`syscall` pulsed during HOLD → ignored; no second pulse.
- **Reset mid-sequence:** `rst` asserted during SAVE → next cycle IDLE, all outputs 0, `irq_pend`=0.
